// File: rtl/spike_aer_encoder_if.sv
// AER output handshake bundle for spike_aer_encoder.
// Optional timestamp field is present only when AER_TIMESTAMP_EN is defined.
interface spike_aer_encoder_if #(
  parameter int ID_WIDTH = 8
`ifdef AER_TIMESTAMP_EN
  ,
  parameter int TS_WIDTH = 16
`endif
);
  logic                aer_valid;
  logic                aer_ready;
  logic [ID_WIDTH-1:0] aer_id;
`ifdef AER_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] aer_ts;
`endif

`ifdef AER_TIMESTAMP_EN
  modport master (output aer_valid, output aer_id, output aer_ts, input aer_ready);
  modport slave  (input aer_valid, input aer_id, input aer_ts, output aer_ready);
`else
  modport master (output aer_valid, output aer_id, input aer_ready);
  modport slave  (input aer_valid, input aer_id, output aer_ready);
`endif
endinterface

// File: rtl/spike_aer_encoder.sv
// spike_aer_encoder: collects per-neuron spike pulses into a pending vector,
// serialises them lowest-index-first into a small event FIFO and presents the
// head event on a valid/ready AER port. Spikes landing on an already pending
// neuron are merged and counted in a saturating drop counter.
// Optional feature macro: AER_TIMESTAMP_EN adds a tick-driven timestamp
// counter whose value is stored with every event and shown on aer_ts.
module spike_aer_encoder #(
  parameter int NUM_NEURONS = 256,
  parameter int ID_WIDTH    = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int TS_WIDTH    = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_NEURONS-1:0] spike_in_valid,
  input  logic                   cfg_enable,
  input  logic                   tick,
  spike_aer_encoder_if.master    aer,
  output logic [15:0]            drop_count,
  output logic                   busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int MRG_W = $clog2(NUM_NEURONS + 1);
  localparam int SUM_W = MRG_W + 17;

  // Elaboration-time sanity checks on the configuration.
  if ((2 ** ID_WIDTH) < NUM_NEURONS) begin : g_bad_id_width
    $error("ID_WIDTH too small for NUM_NEURONS");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end
  if (TS_WIDTH < 1) begin : g_bad_ts_width
    $error("TS_WIDTH must be >= 1");
  end

  // Saturating add of the per-edge merge count into the 16-bit drop counter.
  function automatic logic [15:0] sat_add16(input logic [15:0] acc,
                                            input logic [MRG_W-1:0] inc);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(acc) + SUM_W'(inc);
    if (sum > SUM_W'(16'hFFFF)) return 16'hFFFF;
    return sum[15:0];
  endfunction

  logic [NUM_NEURONS-1:0] pending_q, pending_d;
  logic [15:0]            drop_q, drop_d;
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [ID_WIDTH-1:0]    id_mem [FIFO_DEPTH];

  logic                   enc_any;
  logic [ID_WIDTH-1:0]    enc_idx;
  logic                   fifo_empty, fifo_full;
  logic                   push, pop;
  logic [NUM_NEURONS-1:0] spk_new, clr_mask, pend_kept, merged;
  logic [MRG_W-1:0]       merge_cnt;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop        = aer.aer_ready && !fifo_empty;
  // A full FIFO still accepts a write when the head is leaving on the same edge.
  assign push       = enc_any && (!fifo_full || pop);

  // Priority encoder: lowest set pending bit wins.
  always_comb begin
    enc_any = 1'b0;
    enc_idx = '0;
    for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        enc_any = 1'b1;
        enc_idx = ID_WIDTH'(i);
      end
    end
  end

  // Next pending vector and merge accounting; a new spike on the bit being
  // cleared this edge is kept as a fresh event rather than counted as a drop.
  always_comb begin
    spk_new  = cfg_enable ? spike_in_valid : '0;
    clr_mask = '0;
    if (push) clr_mask[enc_idx] = 1'b1;
    pend_kept = pending_q & ~clr_mask;
    merged    = spk_new & pend_kept;
    merge_cnt = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      merge_cnt = merge_cnt + MRG_W'(merged[i]);
    end
    pending_d = pend_kept | spk_new;
    drop_d    = sat_add16(drop_q, merge_cnt);
  end

  // FIFO occupancy update from the push/pop pair.
  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);
  end

  // Control state: pending vector, FIFO pointers/occupancy, drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      drop_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      pending_q <= pending_d;
      drop_q    <= drop_d;
      count_q   <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Event ID storage; contents are only observable through valid entries.
  always_ff @(posedge clk) begin
    if (push) id_mem[wr_ptr_q] <= enc_idx;
  end

  assign aer.aer_valid = !fifo_empty;
  assign aer.aer_id    = fifo_empty ? '0 : id_mem[rd_ptr_q];
  assign drop_count    = drop_q;
  assign busy          = (|pending_q) || !fifo_empty;

`ifdef AER_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_q;
  logic [TS_WIDTH-1:0] ts_mem [FIFO_DEPTH];

  // Free-running timestep counter advanced by the tick strobe; wraps to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ts_q <= '0;
    else if (tick) ts_q <= ts_q + TS_WIDTH'(1);
  end

  // Each event records the counter value present at its write edge.
  always_ff @(posedge clk) begin
    if (push) ts_mem[wr_ptr_q] <= ts_q;
  end

  assign aer.aer_ts = fifo_empty ? '0 : ts_mem[rd_ptr_q];
`else
  logic unused_tick;
  assign unused_tick = tick;
`endif

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Testbench for spike_aer_encoder: directed scenarios plus a randomized run
// against a queue-based behavioural model of the event encoder.
module tb_spike_aer_encoder;
  localparam int NUM   = 256;
  localparam int IDW   = 8;
  localparam int DEPTH = 16;
  localparam int TSW   = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NUM-1:0] spike_in_valid = '0;
  logic           cfg_enable = 1'b0;
  logic           tick = 1'b0;
  logic [15:0]    drop_count;
  logic           busy;

`ifdef AER_TIMESTAMP_EN
  spike_aer_encoder_if #(.ID_WIDTH(IDW), .TS_WIDTH(TSW)) aer_if();
`else
  spike_aer_encoder_if #(.ID_WIDTH(IDW)) aer_if();
`endif

  spike_aer_encoder #(
    .NUM_NEURONS(NUM), .ID_WIDTH(IDW), .FIFO_DEPTH(DEPTH), .TS_WIDTH(TSW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .spike_in_valid(spike_in_valid),
    .cfg_enable(cfg_enable), .tick(tick), .aer(aer_if),
    .drop_count(drop_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Behavioural model: set of pending neurons, event queue, counters.
  logic [NUM-1:0] m_pend;
  int             m_qid[$];
  int             m_qts[$];
  int             m_drop;
  int             m_ts;
  int             obs_id[$];

  function automatic void model_reset();
    m_pend = '0;
    m_qid.delete();
    m_qts.delete();
    m_drop = 0;
    m_ts = 0;
  endfunction

  function automatic void model_step(input logic [NUM-1:0] spk, input bit en,
                                     input bit tk, input bit rdy);
    bit do_pop;
    bit full;
    int low;
    do_pop = rdy && (m_qid.size() != 0);
    full   = (m_qid.size() == DEPTH);
    low    = -1;
    for (int i = 0; i < NUM; i++) if (m_pend[i] && low < 0) low = i;
    if (do_pop) begin
      void'(m_qid.pop_front());
      void'(m_qts.pop_front());
    end
    if (low >= 0 && (!full || do_pop)) begin
      m_qid.push_back(low);
      m_qts.push_back(m_ts);
      m_pend[low] = 1'b0;
    end
    if (en) begin
      for (int i = 0; i < NUM; i++) begin
        if (spk[i]) begin
          if (m_pend[i]) begin
            if (m_drop < 65535) m_drop++;
          end else begin
            m_pend[i] = 1'b1;
          end
        end
      end
    end
    if (tk) m_ts = (m_ts + 1) % (1 << TSW);
  endfunction

  function automatic logic [NUM-1:0] rand_set(input int n, input int lo, input int hi);
    logic [NUM-1:0] v;
    int k;
    int b;
    v = '0;
    k = 0;
    while (k < n) begin
      b = $urandom_range(hi, lo);
      if (!v[b]) begin
        v[b] = 1'b1;
        k++;
      end
    end
    return v;
  endfunction

  function automatic logic [NUM-1:0] one_bit(input int b);
    logic [NUM-1:0] v;
    v = '0;
    v[b] = 1'b1;
    return v;
  endfunction

  // One clock: drive at negedge, note any handshake, advance model at posedge.
  task automatic cycle(input logic [NUM-1:0] spk, input bit en, input bit tk, input bit rdy);
    @(negedge clk);
    spike_in_valid   = spk;
    cfg_enable       = en;
    tick             = tk;
    aer_if.aer_ready = rdy;
    if (aer_if.aer_valid && rdy) obs_id.push_back(int'(aer_if.aer_id));
    @(posedge clk);
    model_step(spk, en, tk, rdy);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    spike_in_valid = '0;
    aer_if.aer_ready = 1'b0;
    tick = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    obs_id.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    aer_if.aer_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++; if (aer_if.aer_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", aer_if.aer_valid); else passed++;
    checks++; if (aer_if.aer_id !== '0) $display("FAIL reset_id got=%0d exp=0", aer_if.aer_id); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
    checks++; if (drop_count !== 16'd0) $display("FAIL reset_drop got=%0d exp=0", drop_count); else passed++;
`ifdef AER_TIMESTAMP_EN
    checks++; if (aer_if.aer_ts !== '0) $display("FAIL reset_ts got=%0d exp=0", aer_if.aer_ts); else passed++;
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    cycle(one_bit(5), 1'b1, 1'b0, 1'b1);
    checks++; if (aer_if.aer_valid !== 1'b0) $display("FAIL single_capture_valid got=%b exp=0", aer_if.aer_valid); else passed++;
    checks++; if (busy !== 1'b1) $display("FAIL single_capture_busy got=%b exp=1", busy); else passed++;
    cycle('0, 1'b1, 1'b0, 1'b1);
    checks++; if (aer_if.aer_valid !== 1'b1) $display("FAIL single_valid got=%b exp=1", aer_if.aer_valid); else passed++;
    checks++; if (aer_if.aer_id !== 8'd5) $display("FAIL single_id got=%0d exp=5", aer_if.aer_id); else passed++;
    cycle('0, 1'b1, 1'b0, 1'b1);
    checks++; if (aer_if.aer_valid !== 1'b0) $display("FAIL single_after_pop_valid got=%b exp=0", aer_if.aer_valid); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL single_after_pop_busy got=%b exp=0", busy); else passed++;
    checks++; if (obs_id.size() != 1 || obs_id[0] != 5) $display("FAIL single_popped got_n=%0d exp_n=1 id5", obs_id.size()); else passed++;
  endtask

  task automatic test_burst();
    int exp_ids[3];
    exp_ids = '{3, 77, 200};
    do_reset();
    cycle(one_bit(200) | one_bit(3) | one_bit(77), 1'b1, 1'b0, 1'b1);
    checks++; if (aer_if.aer_valid !== 1'b0) $display("FAIL burst_capture_valid got=%b exp=0", aer_if.aer_valid); else passed++;
    for (int k = 0; k < 3; k++) begin
      cycle('0, 1'b1, 1'b0, 1'b1);
      checks++;
      if (aer_if.aer_valid !== 1'b1 || int'(aer_if.aer_id) != exp_ids[k])
        $display("FAIL burst_order k=%0d got valid=%b id=%0d exp id=%0d", k, aer_if.aer_valid, aer_if.aer_id, exp_ids[k]);
      else passed++;
    end
    cycle('0, 1'b1, 1'b0, 1'b1);
    checks++; if (aer_if.aer_valid !== 1'b0) $display("FAIL burst_drained_valid got=%b exp=0", aer_if.aer_valid); else passed++;
  endtask

  task automatic test_backpressure();
    logic [NUM-1:0] v;
    int sorted[$];
    logic [IDW-1:0] held_id;
    bit stable_ok;
    do_reset();
    v = rand_set(20, 0, NUM - 1);
    for (int i = 0; i < NUM; i++) if (v[i]) sorted.push_back(i);
    cycle(v, 1'b1, 1'b0, 1'b0);
    stable_ok = 1'b1;
    held_id = '0;
    for (int c = 0; c < 20; c++) begin
      cycle('0, 1'b1, 1'b0, 1'b0);
      if (c == 0) held_id = aer_if.aer_id;
      else if (aer_if.aer_id !== held_id) stable_ok = 1'b0;
    end
    checks++; if (aer_if.aer_valid !== 1'b1) $display("FAIL bp_valid got=%b exp=1", aer_if.aer_valid); else passed++;
    checks++; if (int'(aer_if.aer_id) != sorted[0]) $display("FAIL bp_head_id got=%0d exp=%0d", aer_if.aer_id, sorted[0]); else passed++;
    checks++; if (!stable_ok) $display("FAIL bp_head_stable got=unstable exp=stable"); else passed++;
    checks++; if (drop_count !== 16'd0) $display("FAIL bp_drop got=%0d exp=0", drop_count); else passed++;
    obs_id.delete();
    for (int c = 0; c < 24; c++) cycle('0, 1'b1, 1'b0, 1'b1);
    checks++; if (obs_id.size() != 20) $display("FAIL bp_count got=%0d exp=20", obs_id.size()); else passed++;
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (k >= obs_id.size() || obs_id[k] != sorted[k])
        $display("FAIL bp_order k=%0d got=%0d exp=%0d", k, (k < obs_id.size()) ? obs_id[k] : -1, sorted[k]);
      else passed++;
    end
    checks++; if (busy !== 1'b0) $display("FAIL bp_busy_end got=%b exp=0", busy); else passed++;
  endtask

  task automatic test_merge();
    logic [NUM-1:0] v;
    int n9;
    do_reset();
    v = '0;
    for (int i = 20; i < 36; i++) v[i] = 1'b1;
    cycle(v, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 17; c++) cycle('0, 1'b1, 1'b0, 1'b0);
    cycle(one_bit(9), 1'b1, 1'b0, 1'b0);
    checks++; if (drop_count !== 16'd0) $display("FAIL merge_first_drop got=%0d exp=0", drop_count); else passed++;
    cycle(one_bit(9), 1'b1, 1'b0, 1'b0);
    checks++; if (drop_count !== 16'd1) $display("FAIL merge_second_drop got=%0d exp=1", drop_count); else passed++;
    obs_id.delete();
    for (int c = 0; c < 20; c++) cycle('0, 1'b1, 1'b0, 1'b1);
    n9 = 0;
    foreach (obs_id[k]) if (obs_id[k] == 9) n9++;
    checks++; if (n9 != 1) $display("FAIL merge_events9 got=%0d exp=1", n9); else passed++;
    checks++; if (obs_id.size() != 17) $display("FAIL merge_total got=%0d exp=17", obs_id.size()); else passed++;

    do_reset();
    cycle(one_bit(9), 1'b1, 1'b0, 1'b1);
    cycle(one_bit(9), 1'b1, 1'b0, 1'b1);
    checks++; if (drop_count !== 16'd0) $display("FAIL collide_drop got=%0d exp=0", drop_count); else passed++;
    for (int c = 0; c < 4; c++) cycle('0, 1'b1, 1'b0, 1'b1);
    n9 = 0;
    foreach (obs_id[k]) if (obs_id[k] == 9) n9++;
    checks++; if (n9 != 2) $display("FAIL collide_events9 got=%0d exp=2", n9); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [NUM-1:0] v;
    bit seen;
    do_reset();
    v = '0;
    for (int i = 40; i < 50; i++) v[i] = 1'b1;
    cycle(v, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 12; c++) cycle('0, 1'b1, 1'b0, 1'b0);
    checks++; if (aer_if.aer_valid !== 1'b1) $display("FAIL rmid_pre_valid got=%b exp=1", aer_if.aer_valid); else passed++;
    rst_n = 1'b0;
    #1;
    checks++; if (aer_if.aer_valid !== 1'b0) $display("FAIL rmid_valid got=%b exp=0", aer_if.aer_valid); else passed++;
    checks++; if (aer_if.aer_id !== '0) $display("FAIL rmid_id got=%0d exp=0", aer_if.aer_id); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rmid_busy got=%b exp=0", busy); else passed++;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    obs_id.delete();
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      cycle('0, 1'b1, 1'b0, 1'b1);
      if (aer_if.aer_valid !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen || obs_id.size() != 0) $display("FAIL rmid_no_events got=%0d events exp=0", obs_id.size()); else passed++;
  endtask

  task automatic test_random();
    logic [NUM-1:0] v;
    int e_id;
    bit e_busy;
    int bad;
    do_reset();
    bad = 0;
    for (int c = 0; c < 600; c++) begin
      v = '0;
      if ($urandom_range(99, 0) < 40) begin
        if ($urandom_range(1, 0) == 1) v = rand_set($urandom_range(4, 1), 0, 31);
        else v = rand_set($urandom_range(3, 1), 0, NUM - 1);
      end
      cycle(v, $urandom_range(9, 0) != 0, $urandom_range(2, 0) == 0, $urandom_range(9, 0) < 6);
      e_id = (m_qid.size() != 0) ? m_qid[0] : 0;
      e_busy = (m_pend != '0) || (m_qid.size() != 0);
      checks++;
      if (aer_if.aer_valid !== (m_qid.size() != 0)) begin
        $display("FAIL rand_valid cyc=%0d got=%b exp=%b", c, aer_if.aer_valid, m_qid.size() != 0); bad++;
      end else passed++;
      if (m_qid.size() != 0) begin
        checks++;
        if (int'(aer_if.aer_id) != e_id) begin
          $display("FAIL rand_id cyc=%0d got=%0d exp=%0d", c, aer_if.aer_id, e_id); bad++;
        end else passed++;
`ifdef AER_TIMESTAMP_EN
        checks++;
        if (int'(aer_if.aer_ts) != m_qts[0]) begin
          $display("FAIL rand_ts cyc=%0d got=%0d exp=%0d", c, aer_if.aer_ts, m_qts[0]); bad++;
        end else passed++;
`endif
      end
      checks++;
      if (drop_count !== 16'(m_drop)) begin
        $display("FAIL rand_drop cyc=%0d got=%0d exp=%0d", c, drop_count, m_drop); bad++;
      end else passed++;
      checks++;
      if (busy !== e_busy) begin
        $display("FAIL rand_busy cyc=%0d got=%b exp=%b", c, busy, e_busy); bad++;
      end else passed++;
      if (bad > 20) break;
    end
  endtask

`ifdef AER_TIMESTAMP_EN
  task automatic test_timestamp();
    do_reset();
    for (int c = 0; c < 3; c++) cycle('0, 1'b1, 1'b1, 1'b0);
    cycle(one_bit(1), 1'b1, 1'b0, 1'b0);
    cycle('0, 1'b1, 1'b0, 1'b0);
    checks++; if (aer_if.aer_valid !== 1'b1 || aer_if.aer_id !== 8'd1) $display("FAIL ts_event got valid=%b id=%0d exp valid=1 id=1", aer_if.aer_valid, aer_if.aer_id); else passed++;
    checks++; if (aer_if.aer_ts !== 16'd3) $display("FAIL ts_three got=%0d exp=3", aer_if.aer_ts); else passed++;
    for (int c = 0; c < 65533; c++) cycle('0, 1'b1, 1'b1, 1'b1);
    cycle(one_bit(1), 1'b1, 1'b0, 1'b1);
    cycle('0, 1'b1, 1'b0, 1'b0);
    checks++; if (aer_if.aer_valid !== 1'b1) $display("FAIL ts_wrap_valid got=%b exp=1", aer_if.aer_valid); else passed++;
    checks++; if (aer_if.aer_ts !== 16'd0) $display("FAIL ts_wrap got=%0d exp=0", aer_if.aer_ts); else passed++;
  endtask
`endif

  initial begin
    aer_if.aer_ready = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_merge();
    test_reset_mid();
    test_random();
`ifdef AER_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
